adma_dm_dst_axis: RTL and testbench
===================================

Name: adma_dm_dst_axis

Overview:
- Destination-side AXI-Stream datamover, directly downstream of the source datamover's read-data path.
- Takes per-transaction descriptors (ID, length, destination) and a stream of DMA data beats.
- Emits them as an AXI-Stream master: TID and TDEST come from the descriptor, TLAST is generated from the beat count, and one completion pulse is raised per transaction.

Parameters:
- DMA_CHN_NUM, 4, number of DMA channels.
- ATX_DST_DATA_W, 256, TDATA width in bits.
- ATX_DST_BYTE_AMT, ATX_DST_DATA_W/8, TKEEP/TSTRB width.
- DST_TDEST_W, 2, TDEST width.
- MST_ID_W, 5, transaction ID / TID width.
- ATX_LEN_W, 8, beat-count width; a transaction carries len+1 beats.
- ATX_NUM_OSTD, DMA_CHN_NUM, descriptor FIFO depth; power of 2, ≥2.

Ports:
- aclk, in, 1, clock; all state on the rising edge.
- areset, in, 1, reset; asynchronous, active-high.
- atx_awid, in, MST_ID_W, descriptor ID, driven onto TID.
- atx_awlen, in, ATX_LEN_W, descriptor length (beats − 1).
- atx_tdest, in, DST_TDEST_W, descriptor TDEST.
- atx_vld, in, 1, descriptor valid.
- atx_rdy, out, 1, descriptor ready.
- atx_wdata, in, ATX_DST_DATA_W, data beat.
- atx_wdata_vld, in, 1, data valid.
- atx_wdata_rdy, out, 1, data ready.
- atx_done, out, 1, one-cycle pulse when a transaction's last beat is accepted downstream.
- atx_done_id, out, MST_ID_W, ID of the completed transaction; valid while atx_done is high.
- m_tid_o, out, MST_ID_W, AXI-Stream TID.
- m_tdest_o, out, DST_TDEST_W, AXI-Stream TDEST.
- m_tdata_o, out, ATX_DST_DATA_W, AXI-Stream TDATA.
- m_tkeep_o, out, ATX_DST_BYTE_AMT, AXI-Stream TKEEP.
- m_tstrb_o, out, ATX_DST_BYTE_AMT, AXI-Stream TSTRB.
- m_tlast_o, out, 1, AXI-Stream TLAST.
- m_tvalid_o, out, 1, AXI-Stream TVALID.
- m_tready_i, in, 1, AXI-Stream TREADY.

Behaviour:
- Reset (areset high, asynchronous):
  - Descriptor FIFO emptied, beat counter cleared to 0.
  - m_tvalid_o=0, m_tlast_o=0, atx_done=0, atx_done_id=0, m_tid_o/m_tdest_o/m_tdata_o=0, atx_wdata_rdy=0.
  - atx_rdy=0 while areset is high; atx_rdy=1 in the first cycle after release.
  - Reset mid-transaction discards the in-flight beat and all queued descriptors; no atx_done is issued for them.
- Descriptor FIFO:
  - Push on atx_vld & atx_rdy; atx_rdy = !full.
  - When full, atx_rdy stays 0 even if a pop occurs in the same cycle; no same-cycle push-on-pop.
  - Descriptors are consumed strictly in order. Head = {id, len, tdest}; head_vld = !empty.
- Output register:
  - One output stage. atx_wdata_rdy = head_vld & (!m_tvalid_o | m_tready_i); the path is combinational from m_tready_i.
  - On accept (atx_wdata_vld & atx_wdata_rdy): register wdata, head id → TID, head tdest → TDEST, TLAST = (cnt == head_len); set m_tvalid_o=1.
  - Latency: a data beat appears on m_* one cycle after acceptance. Full throughput: one beat/cycle while m_tready_i=1.
  - m_tvalid_o clears when m_tready_i=1 and no new beat is accepted that cycle.
  - Output payload is held stable while m_tvalid_o & !m_tready_i (AXI-Stream rule).
  - m_tkeep_o and m_tstrb_o are all ones whenever m_tvalid_o=1.
- Beat counter (ATX_LEN_W bits):
  - Increments on each accepted data beat.
  - On acceptance of the beat where cnt == head_len: counter resets to 0 and the descriptor is popped in that same cycle. The next beat uses the next descriptor; there is no bubble if the next descriptor is present.
  - len=0 gives a single beat with TLAST=1. len=2^ATX_LEN_W−1 (255) must not overflow; the compare happens before the increment.
- Completion:
  - atx_done pulses for 1 cycle on the cycle m_tvalid_o & m_tready_i & m_tlast_o; atx_done_id = m_tid_o of that beat.
- Boundaries:
  - No descriptor present: data is not accepted (atx_wdata_rdy=0), even if atx_wdata_vld=1.
  - A descriptor pushed into an empty FIFO is usable on the next cycle.
  - Back-pressure on m_tready_i stalls both the counter and FIFO pops.

Test Plan:
- Single descriptor {id=3, len=3, tdest=1}, 4 beats with m_tready_i=1 → 4 consecutive m_tvalid_o beats, each 1 cycle after its accept; TID=3, TDEST=1; TLAST only on beat 4; atx_done=1 with atx_done_id=3 on that cycle.
- Descriptors {id=1, len=0}, {id=2, len=1} preloaded, 3 back-to-back beats → TLAST on beats 1 and 3; atx_done for id 1 then id 2; no idle cycle between the transactions.
- Push 4 descriptors with no data → atx_rdy=0 after the 4th; the 5th is held until the first transaction completes and pops; atx_wdata_rdy=0 before any descriptor exists.
- Random m_tready_i at 50% over {len=7} → m_* payload stable while stalled; 8 beats delivered in order; exactly one atx_done.
- len=255, 256 beats → TLAST only on beat 256; counter returns to 0 with no wrap-induced early TLAST.
- Assert areset at beat 2 of a len=3 transfer → m_tvalid_o=0 and atx_done=0 immediately; after release atx_rdy=1, the FIFO is empty, and a new {len=0} transfer completes correctly.

Source files
------------

// File: rtl/adma_dm_dst_axis.sv
// Descriptor FIFO: in-order queue of {id, len, tdest} records feeding the stream formatter.
// Latency: a pushed entry is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: o_full blocks pushes (even when a pop happens in the same cycle); pops only when non-empty.
module adma_dm_dst_axis_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];

  // Read/write pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_ONE;
      if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_dat   = r_mem[r_rptr[AW-1:0]];
endmodule

// Destination datamover: tags DMA data beats with descriptor TID/TDEST, generates TLAST and completions.
// Latency: an accepted data beat appears on the AXI-Stream master one cycle later; full throughput.
// Backpressure: atx_wdata_rdy follows m_tready_i combinationally; stalls freeze counter and descriptor pops.
module adma_dm_dst_axis #(
  parameter int DMA_CHN_NUM      = 4,
  parameter int ATX_DST_DATA_W   = 256,
  parameter int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
  parameter int DST_TDEST_W      = 2,
  parameter int MST_ID_W         = 5,
  parameter int ATX_LEN_W        = 8,
  parameter int ATX_NUM_OSTD     = DMA_CHN_NUM
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [MST_ID_W-1:0]         atx_awid,
  input  logic [ATX_LEN_W-1:0]        atx_awlen,
  input  logic [DST_TDEST_W-1:0]      atx_tdest,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]   atx_wdata,
  input  logic                        atx_wdata_vld,
  output logic                        atx_wdata_rdy,
  output logic                        atx_done,
  output logic [MST_ID_W-1:0]         atx_done_id,
  output logic [MST_ID_W-1:0]         m_tid_o,
  output logic [DST_TDEST_W-1:0]      m_tdest_o,
  output logic [ATX_DST_DATA_W-1:0]   m_tdata_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tkeep_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tstrb_o,
  output logic                        m_tlast_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i
);
  localparam int DESC_W = MST_ID_W + ATX_LEN_W + DST_TDEST_W;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_acc;
  logic                      w_last_beat;
  logic [DESC_W-1:0]         w_head;
  logic [MST_ID_W-1:0]       w_head_id;
  logic [ATX_LEN_W-1:0]      w_head_len;
  logic [DST_TDEST_W-1:0]    w_head_tdest;

  logic [ATX_LEN_W-1:0]      r_cnt;
  logic                      r_tvalid;
  logic                      r_tlast;
  logic [MST_ID_W-1:0]       r_tid;
  logic [DST_TDEST_W-1:0]    r_tdest;
  logic [ATX_DST_DATA_W-1:0] r_tdata;

  // Ready is decided from the occupancy at the start of the cycle, so a full FIFO
  // never accepts a descriptor in the same cycle it pops one.
  assign atx_rdy = !areset && !w_full;
  assign w_push  = atx_vld && atx_rdy;

  adma_dm_dst_axis_fifo #(
    .W     (DESC_W),
    .DEPTH (ATX_NUM_OSTD)
  ) u_desc_fifo (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_push  (w_push),
    .i_dat   ({atx_awid, atx_awlen, atx_tdest}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dat   (w_head)
  );

  assign {w_head_id, w_head_len, w_head_tdest} = w_head;

  // A beat is only taken when a descriptor exists to tag it and the output slot frees this cycle.
  assign atx_wdata_rdy = !w_empty && (!r_tvalid || m_tready_i);
  assign w_acc         = atx_wdata_vld && atx_wdata_rdy;
  // Compare before increment so len = all-ones never wraps into an early TLAST.
  assign w_last_beat   = (r_cnt == w_head_len);
  assign w_pop         = w_acc && w_last_beat;

  // Beat counter within the current transaction; restarts when the last beat is accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= w_last_beat ? '0 : r_cnt + {{(ATX_LEN_W-1){1'b0}}, 1'b1};
    end
  end

  // Single output stage: load on accept, drop valid once drained, otherwise hold the payload.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tid    <= '0;
      r_tdest  <= '0;
      r_tdata  <= '0;
    end else if (w_acc) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_last_beat;
      r_tid    <= w_head_id;
      r_tdest  <= w_head_tdest;
      r_tdata  <= atx_wdata;
    end else if (m_tready_i) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_tvalid_o  = r_tvalid;
  assign m_tlast_o   = r_tlast;
  assign m_tid_o     = r_tid;
  assign m_tdest_o   = r_tdest;
  assign m_tdata_o   = r_tdata;
  assign m_tkeep_o   = {ATX_DST_BYTE_AMT{r_tvalid}};
  assign m_tstrb_o   = {ATX_DST_BYTE_AMT{r_tvalid}};

  // Completion coincides with the downstream handshake of the TLAST beat.
  assign atx_done    = r_tvalid && m_tready_i && r_tlast;
  assign atx_done_id = atx_done ? r_tid : '0;
endmodule

// File: tb/tb_adma_dm_dst_axis.sv
// Bench for adma_dm_dst_axis: descriptor table, hand-written corner sequences, random data and TREADY.
// Reference model: queues of descriptors and expected beats derived from the transaction rules.
// Every mismatch prints a FAIL line; one summary line at the end.
module tb_adma_dm_dst_axis;
  localparam int DW    = 256;
  localparam int BW    = DW / 8;
  localparam int IW    = 5;
  localparam int LW    = 8;
  localparam int TW    = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [IW-1:0] id;
    logic [LW-1:0] len;
    logic [TW-1:0] tdest;
  } desc_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [TW-1:0] tdest;
    logic          last;
  } beat_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [LW-1:0] len;
    logic [TW-1:0] tdest;
    int            rdy_pct;
    int            exp_beats;
    int            exp_dones;
  } vec_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [IW-1:0] atx_awid;
  logic [LW-1:0] atx_awlen;
  logic [TW-1:0] atx_tdest;
  logic          atx_vld;
  logic          atx_rdy;
  logic [DW-1:0] atx_wdata;
  logic          atx_wdata_vld;
  logic          atx_wdata_rdy;
  logic          atx_done;
  logic [IW-1:0] atx_done_id;
  logic [IW-1:0] m_tid_o;
  logic [TW-1:0] m_tdest_o;
  logic [DW-1:0] m_tdata_o;
  logic [BW-1:0] m_tkeep_o;
  logic [BW-1:0] m_tstrb_o;
  logic          m_tlast_o;
  logic          m_tvalid_o;
  logic          m_tready_i;

  always #5 aclk = ~aclk;

  adma_dm_dst_axis #(
    .DMA_CHN_NUM(4), .ATX_DST_DATA_W(DW), .ATX_DST_BYTE_AMT(BW), .DST_TDEST_W(TW),
    .MST_ID_W(IW), .ATX_LEN_W(LW), .ATX_NUM_OSTD(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .atx_awid(atx_awid), .atx_awlen(atx_awlen), .atx_tdest(atx_tdest),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_wdata(atx_wdata), .atx_wdata_vld(atx_wdata_vld), .atx_wdata_rdy(atx_wdata_rdy),
    .atx_done(atx_done), .atx_done_id(atx_done_id),
    .m_tid_o(m_tid_o), .m_tdest_o(m_tdest_o), .m_tdata_o(m_tdata_o),
    .m_tkeep_o(m_tkeep_o), .m_tstrb_o(m_tstrb_o), .m_tlast_o(m_tlast_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int beats_seen = 0;
  int dones_seen = 0;
  int last_done_id = -1;

  desc_t         mdesc_q[$];
  beat_t         exp_q[$];
  int            acc_cyc[$];
  int            midx = 0;
  logic          acc_flag = 1'b0;
  logic [DW-1:0] acc_data;
  logic          stall = 1'b0;
  beat_t         held;
  beat_t         m_e;
  beat_t         m_o;
  desc_t         m_d;
  vec_t          vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: each accepted beat takes the oldest open descriptor; the (len+1)-th beat closes it.
  always @(posedge aclk) begin
    cyc++;
    if (areset) begin
      mdesc_q.delete();
      exp_q.delete();
      midx = 0;
      acc_flag = 1'b0;
    end else begin
      acc_flag = 1'b0;
      if (atx_wdata_vld && atx_wdata_rdy) begin
        if (mdesc_q.size() == 0) begin
          chk("accept_without_descriptor", 1, 0);
        end else begin
          m_e.data  = atx_wdata;
          m_e.id    = mdesc_q[0].id;
          m_e.tdest = mdesc_q[0].tdest;
          m_e.last  = (midx == int'(mdesc_q[0].len));
          exp_q.push_back(m_e);
          acc_flag = 1'b1;
          acc_data = atx_wdata;
          acc_cyc.push_back(cyc);
          if (m_e.last) begin
            void'(mdesc_q.pop_front());
            midx = 0;
          end else begin
            midx++;
          end
        end
      end
      if (atx_vld && atx_rdy) begin
        m_d.id    = atx_awid;
        m_d.len   = atx_awlen;
        m_d.tdest = atx_tdest;
        mdesc_q.push_back(m_d);
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (areset) begin
      stall = 1'b0;
    end else begin
      chk("atx_rdy", int'(atx_rdy), int'(mdesc_q.size() < DEPTH));
      chk("atx_wdata_rdy", int'(atx_wdata_rdy),
          int'((mdesc_q.size() > 0) && (!m_tvalid_o || m_tready_i)));
      if (m_tvalid_o) begin
        chk("tkeep_ones", int'(&m_tkeep_o), 1);
        chk("tstrb_ones", int'(&m_tstrb_o), 1);
      end
      if (acc_flag) begin
        chk("latency_vld", int'(m_tvalid_o), 1);
        chk_w("latency_data", m_tdata_o, acc_data);
      end
      if (stall) begin
        chk("hold_vld", int'(m_tvalid_o), 1);
        chk_w("hold_data", m_tdata_o, held.data);
        chk("hold_tid", int'(m_tid_o), int'(held.id));
        chk("hold_tdest", int'(m_tdest_o), int'(held.tdest));
        chk("hold_tlast", int'(m_tlast_o), int'(held.last));
      end
      stall      = m_tvalid_o && !m_tready_i;
      held.data  = m_tdata_o;
      held.id    = m_tid_o;
      held.tdest = m_tdest_o;
      held.last  = m_tlast_o;
      if (m_tvalid_o && m_tready_i) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          m_o = exp_q.pop_front();
          chk_w("tdata", m_tdata_o, m_o.data);
          chk("tid", int'(m_tid_o), int'(m_o.id));
          chk("tdest", int'(m_tdest_o), int'(m_o.tdest));
          chk("tlast", int'(m_tlast_o), int'(m_o.last));
          chk("done", int'(atx_done), int'(m_o.last));
          if (m_o.last) chk("done_id", int'(atx_done_id), int'(m_o.id));
        end
      end else begin
        chk("done_idle", int'(atx_done), 0);
      end
      if (atx_done) begin
        dones_seen++;
        last_done_id = int'(atx_done_id);
      end
    end
  end

  // Randomised downstream TREADY, changed just after each rising edge.
  initial begin
    m_tready_i = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready_i = (int'($urandom_range(99)) < rdy_pct);
    end
  end

  task automatic push_desc(input logic [IW-1:0] id, input logic [LW-1:0] len, input logic [TW-1:0] td);
    bit got = 0;
    int n = 0;
    atx_awid = id; atx_awlen = len; atx_tdest = td; atx_vld = 1'b1;
    while (!got && n < 3000) begin
      @(negedge aclk);
      got = atx_rdy;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!got) chk("push_timeout", 1, 0);
    atx_vld = 1'b0;
  endtask

  task automatic send_beats(input int nb);
    for (int i = 0; i < nb; i++) begin
      bit got = 0;
      int n = 0;
      atx_wdata = rnd256();
      atx_wdata_vld = 1'b1;
      while (!got && n < 3000) begin
        @(negedge aclk);
        got = atx_wdata_rdy;
        @(posedge aclk);
        #1;
        n++;
      end
      if (!got) begin
        chk("beat_timeout", 1, 0);
        break;
      end
    end
    atx_wdata_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() > 0 || mdesc_q.size() > 0) && n < 5000) begin
      @(posedge aclk);
      n++;
    end
    chk("drain_in_time", int'(n < 5000), 1);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic set_rdy(input int pct);
    rdy_pct = pct;
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, nb;
    desc_t rd[3];

    vecs[0] = '{5'd3,  8'd3,   2'd1, 100, 4,   1};
    vecs[1] = '{5'd9,  8'd7,   2'd2, 50,  8,   1};
    vecs[2] = '{5'd17, 8'd0,   2'd3, 100, 1,   1};
    vecs[3] = '{5'd5,  8'd255, 2'd0, 100, 256, 1};
    vecs[4] = '{5'd30, 8'd15,  2'd2, 30,  16,  1};

    areset = 1'b0;
    atx_awid = '0; atx_awlen = '0; atx_tdest = '0; atx_vld = 1'b0;
    atx_wdata = '0; atx_wdata_vld = 1'b0;
    #2;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_atx_rdy", int'(atx_rdy), 0);
    chk("rst_tvalid", int'(m_tvalid_o), 0);
    chk("rst_tlast", int'(m_tlast_o), 0);
    chk("rst_done", int'(atx_done), 0);
    chk("rst_done_id", int'(atx_done_id), 0);
    chk("rst_tid", int'(m_tid_o), 0);
    chk("rst_tdest", int'(m_tdest_o), 0);
    chk_w("rst_tdata", m_tdata_o, '0);
    chk("rst_wdata_rdy", int'(atx_wdata_rdy), 0);
    areset = 1'b0;
    #1;
    chk("post_rst_atx_rdy", int'(atx_rdy), 1);
    @(posedge aclk);
    #1;

    // Table-driven single-descriptor transactions.
    for (int v = 0; v < 5; v++) begin
      set_rdy(vecs[v].rdy_pct);
      b0 = beats_seen;
      d0 = dones_seen;
      push_desc(vecs[v].id, vecs[v].len, vecs[v].tdest);
      send_beats(vecs[v].exp_beats);
      wait_drain();
      chk($sformatf("vec%0d_beats", v), beats_seen - b0, vecs[v].exp_beats);
      chk($sformatf("vec%0d_dones", v), dones_seen - d0, vecs[v].exp_dones);
      chk($sformatf("vec%0d_done_id", v), last_done_id, int'(vecs[v].id));
    end

    // Two preloaded descriptors, back-to-back beats with no bubble between transactions.
    set_rdy(100);
    d0 = dones_seen;
    push_desc(5'd1, 8'd0, 2'd1);
    push_desc(5'd2, 8'd1, 2'd2);
    acc_cyc.delete();
    send_beats(3);
    chk("b2b_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) chk("b2b_span", acc_cyc[2] - acc_cyc[0], 2);
    wait_drain();
    chk("b2b_dones", dones_seen - d0, 2);
    chk("b2b_last_id", last_done_id, 2);

    // No descriptor: data refused. Then fill the FIFO and hold a fifth descriptor.
    atx_wdata = rnd256();
    atx_wdata_vld = 1'b1;
    @(negedge aclk);
    chk("wrdy_no_desc", int'(atx_wdata_rdy), 0);
    @(posedge aclk);
    #1;
    atx_wdata_vld = 1'b0;
    d0 = dones_seen;
    for (int i = 0; i < 4; i++) push_desc(IW'(10 + i), 8'd0, TW'(i));
    @(negedge aclk);
    chk("rdy_full", int'(atx_rdy), 0);
    atx_awid = 5'd14; atx_awlen = 8'd0; atx_tdest = 2'd2; atx_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("rdy_held_full", int'(atx_rdy), 0);
    end
    @(posedge aclk);
    #1;
    fork
      push_desc(5'd14, 8'd0, 2'd2);
      send_beats(5);
    join
    wait_drain();
    chk("full_dones", dones_seen - d0, 5);
    chk("full_last_id", last_done_id, 14);

    // Random descriptors and random backpressure.
    set_rdy(60);
    d0 = dones_seen;
    b0 = beats_seen;
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      rd[i].id    = IW'($urandom);
      rd[i].len   = LW'($urandom_range(9));
      rd[i].tdest = TW'($urandom);
      nb += int'(rd[i].len) + 1;
      push_desc(rd[i].id, rd[i].len, rd[i].tdest);
    end
    send_beats(nb);
    wait_drain();
    chk("rand_beats", beats_seen - b0, nb);
    chk("rand_dones", dones_seen - d0, 3);
    chk("rand_last_id", last_done_id, int'(rd[2].id));

    // Reset in the middle of a len=3 transfer, then a fresh single-beat transfer.
    set_rdy(100);
    d0 = dones_seen;
    push_desc(5'd4, 8'd3, 2'd1);
    send_beats(2);
    chk("pre_rst_tvalid", int'(m_tvalid_o), 1);
    areset = 1'b1;
    #1;
    chk("mid_rst_tvalid", int'(m_tvalid_o), 0);
    chk("mid_rst_done", int'(atx_done), 0);
    chk("mid_rst_atx_rdy", int'(atx_rdy), 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    chk("rel_atx_rdy", int'(atx_rdy), 1);
    chk("rel_dones", dones_seen - d0, 0);
    atx_wdata = rnd256();
    atx_wdata_vld = 1'b1;
    @(negedge aclk);
    chk("rel_fifo_empty", int'(atx_wdata_rdy), 0);
    @(posedge aclk);
    #1;
    atx_wdata_vld = 1'b0;
    b0 = beats_seen;
    push_desc(5'd21, 8'd0, 2'd3);
    send_beats(1);
    wait_drain();
    chk("post_rst_beats", beats_seen - b0, 1);
    chk("post_rst_dones", dones_seen - d0, 1);
    chk("post_rst_id", last_done_id, 21);
    chk("final_exp_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
